// File: rtl/input_frame_parser.sv
// Ingress frame parser: registers each accepted AXIS beat, tags it with its frame field and
// summarises every started frame. Define INPUT_PARSER_STATS_EN to add the saturating frame counters.
module input_frame_parser #(
  parameter int                DATA_W            = 16,
  parameter logic [DATA_W-1:0] SFD               = DATA_W'(16'hAAAB),
  parameter int                DST_BEATS         = 3,
  parameter int                SRC_BEATS         = 3,
  parameter int                TYPE_BEATS        = 1,
  parameter int                MIN_PAYLOAD_BEATS = 23,
  parameter int                MAX_PAYLOAD_BEATS = 750,
  parameter int                LEN_W             = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              s_tvalid,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic              s_tlast,
  output logic              s_tready,
  input  logic              drop_current,
  input  logic              almost_full,
  output logic              pkt_tvalid,
  output logic [DATA_W-1:0] pkt_tdata,
  output logic              pkt_tlast,
  output logic [4:0]        status,
  output logic              incomplete_frame,
  output logic              frame_done,
  output logic [LEN_W-1:0]  frame_len,
  output logic [1:0]        frame_err,
  output logic              frame_dropped
`ifdef INPUT_PARSER_STATS_EN
  ,
  input  logic              stat_clr,
  output logic [15:0]       stat_good,
  output logic [15:0]       stat_runt,
  output logic [15:0]       stat_giant,
  output logic [15:0]       stat_dropped
`endif
);

  typedef enum logic [2:0] {IDLE, DST, SRC, TYPE, PAYLOAD, MASK} state_t;

  localparam int HDR = 1 + DST_BEATS + SRC_BEATS + TYPE_BEATS;
  localparam logic [LEN_W-1:0] HDR_LEN   = LEN_W'(HDR);
  localparam logic [LEN_W-1:0] RUNT_LEN  = LEN_W'(HDR + MIN_PAYLOAD_BEATS);
  localparam logic [LEN_W-1:0] GIANT_LEN = LEN_W'(HDR + MAX_PAYLOAD_BEATS);
  localparam logic [LEN_W-1:0] PAY_MAX   = LEN_W'(MAX_PAYLOAD_BEATS);
  localparam logic [LEN_W-1:0] DST_LAST  = LEN_W'(DST_BEATS - 1);
  localparam logic [LEN_W-1:0] SRC_LAST  = LEN_W'(SRC_BEATS - 1);
  localparam logic [LEN_W-1:0] TYPE_LAST = LEN_W'(TYPE_BEATS - 1);

  state_t             state, state_n, eff;
  logic [LEN_W-1:0]   field_cnt, field_cnt_n, pay_cnt, pay_cnt_n, len_cnt, len_cnt_n;
  logic               drop_q, drop_n, drop_act, acc, fwd;
  logic               done_n, trunc, giant, runt, dropped_q;
  logic [4:0]         st_n;
  logic [1:0]         err_n;

  assign s_tready = ~reset & ((state != IDLE) | ~almost_full);
  assign acc      = s_tvalid & s_tready;
  // a verdict arriving alongside an already-registered tlast still marks that frame
  assign frame_dropped = dropped_q | (frame_done & drop_current);

  always_comb begin
    state_n     = state;
    field_cnt_n = field_cnt;
    pay_cnt_n   = pay_cnt;
    len_cnt_n   = len_cnt;
    drop_n      = drop_q;
    st_n        = 5'b00000;
    done_n      = 1'b0;
    fwd         = 1'b0;
    drop_act    = drop_current && (state != IDLE) && !pkt_tlast;
    eff         = drop_act ? MASK : state;
    if (drop_act) begin
      state_n = MASK;
      drop_n  = 1'b1;
    end
    if (acc) begin
      fwd = (eff != IDLE);
      if (eff != IDLE) len_cnt_n = (&len_cnt) ? len_cnt : len_cnt + 1'b1;
      case (eff)
        IDLE: if (s_tdata == SFD && !s_tlast) begin
          st_n        = 5'b00001;
          state_n     = DST;
          field_cnt_n = '0;
          len_cnt_n   = LEN_W'(1);
          drop_n      = 1'b0;
          fwd         = 1'b1;
        end
        DST: begin
          st_n = 5'b00011;
          if (field_cnt == DST_LAST) begin state_n = SRC; field_cnt_n = '0; end
          else field_cnt_n = field_cnt + 1'b1;
        end
        SRC: begin
          st_n = 5'b00101;
          if (field_cnt == SRC_LAST) begin state_n = TYPE; field_cnt_n = '0; end
          else field_cnt_n = field_cnt + 1'b1;
        end
        TYPE: begin
          st_n = 5'b01001;
          if (field_cnt == TYPE_LAST) begin
            state_n = PAYLOAD; field_cnt_n = '0; pay_cnt_n = '0;
          end else field_cnt_n = field_cnt + 1'b1;
        end
        PAYLOAD: begin
          pay_cnt_n = (&pay_cnt) ? pay_cnt : pay_cnt + 1'b1;
          if (pay_cnt_n > PAY_MAX) state_n = MASK;
          else st_n = 5'b10001;
        end
        default: ;
      endcase
      if (s_tlast && eff != IDLE) begin
        state_n = IDLE;
        done_n  = 1'b1;
      end
    end
    // error code derives from beat count alone so a drop cannot disturb it
    trunc = len_cnt_n <= HDR_LEN;
    giant = len_cnt_n > GIANT_LEN;
    runt  = len_cnt_n < RUNT_LEN;
    err_n = trunc ? 2'b11 : giant ? 2'b10 : runt ? 2'b01 : 2'b00;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      field_cnt        <= '0;
      pay_cnt          <= '0;
      len_cnt          <= '0;
      drop_q           <= 1'b0;
      pkt_tvalid       <= 1'b0;
      pkt_tdata        <= '0;
      pkt_tlast        <= 1'b0;
      status           <= '0;
      incomplete_frame <= 1'b0;
      frame_done       <= 1'b0;
      frame_len        <= '0;
      frame_err        <= '0;
      dropped_q        <= 1'b0;
    end else begin
      state            <= state_n;
      field_cnt        <= field_cnt_n;
      pay_cnt          <= pay_cnt_n;
      len_cnt          <= len_cnt_n;
      drop_q           <= drop_n;
      pkt_tvalid       <= fwd;
      if (fwd) pkt_tdata <= s_tdata;
      pkt_tlast        <= fwd & s_tlast;
      status           <= st_n;
      incomplete_frame <= done_n & trunc;
      frame_done       <= done_n;
      frame_len        <= done_n ? len_cnt_n : '0;
      frame_err        <= done_n ? err_n : 2'b00;
      dropped_q        <= done_n & drop_n;
    end
  end

`ifdef INPUT_PARSER_STATS_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_good <= '0; stat_runt <= '0; stat_giant <= '0; stat_dropped <= '0;
    end else if (stat_clr) begin
      stat_good <= '0; stat_runt <= '0; stat_giant <= '0; stat_dropped <= '0;
    end else if (frame_done) begin
      if (frame_err == 2'b00 && !(&stat_good))  stat_good  <= stat_good + 16'd1;
      if (frame_err == 2'b01 && !(&stat_runt))  stat_runt  <= stat_runt + 16'd1;
      if (frame_err == 2'b10 && !(&stat_giant)) stat_giant <= stat_giant + 16'd1;
      if (frame_dropped && !(&stat_dropped))    stat_dropped <= stat_dropped + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_input_frame_parser.sv
// Randomized bench for input_frame_parser: frames are described by beat index and checked
// against expectations derived from field lengths and payload limits.
module tb_input_frame_parser;
  localparam logic [15:0] SFD_V = 16'hAAAB;
  localparam int MINP = 23, MAXP = 750, HDR = 8;

  logic        clk, reset, s_tvalid, s_tlast, s_tready, drop_current, almost_full;
  logic [15:0] s_tdata, pkt_tdata;
  logic        pkt_tvalid, pkt_tlast, incomplete_frame, frame_done, frame_dropped;
  logic [4:0]  status;
  logic [11:0] frame_len;
  logic [1:0]  frame_err;

  input_frame_parser dut (
    .clk(clk), .reset(reset), .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast),
    .s_tready(s_tready), .drop_current(drop_current), .almost_full(almost_full),
    .pkt_tvalid(pkt_tvalid), .pkt_tdata(pkt_tdata), .pkt_tlast(pkt_tlast), .status(status),
    .incomplete_frame(incomplete_frame), .frame_done(frame_done), .frame_len(frame_len),
    .frame_err(frame_err), .frame_dropped(frame_dropped));

  typedef struct {
    logic [15:0] d;
    logic        last;
    logic [4:0]  st;
    logic        done;
    logic [11:0] len;
    logic [1:0]  err;
    logic        drp;
    logic        inc;
    logic        drop_here;
  } exp_t;

  exp_t expq[$];
  exp_t fr[$];
  int   errs = 0, checks = 0;
  int   gap_max = 0;
  bit   af_rand = 0;

  initial begin clk = 0; forever #5 clk = ~clk; end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // field of beat k (1 = SFD) in a frame dropped while beat d was on the output (d=0: no drop)
  function automatic logic [4:0] exp_status(input int k, input int d);
    if (d > 0 && k > d)      return 5'h00;
    if (k == 1)              return 5'h01;
    if (k <= 4)              return 5'h03;
    if (k <= 7)              return 5'h05;
    if (k == 8)              return 5'h09;
    if (k <= HDR + MAXP)     return 5'h11;
    return 5'h00;
  endfunction

  task automatic make_frame(input int n, input int d);
    exp_t e;
    int pay;
    pay = n - HDR;
    fr.delete();
    for (int k = 1; k <= n; k++) begin
      e.d         = (k == 1) ? SFD_V : 16'($urandom);
      e.last      = (k == n);
      e.st        = exp_status(k, d);
      e.done      = (k == n);
      e.len       = 12'(n);
      e.err       = (n <= HDR) ? 2'b11 : (pay > MAXP) ? 2'b10 : (pay < MINP) ? 2'b01 : 2'b00;
      e.drp       = (d > 0);
      e.inc       = (k == n) && (n <= HDR);
      e.drop_here = (k == d);
      fr.push_back(e);
    end
  endtask

  task automatic send_beat(input exp_t e, input bit push);
    int n;
    repeat ($urandom_range(0, gap_max)) begin
      @(negedge clk); s_tvalid = 0;
      if (af_rand) almost_full = ($urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    s_tvalid = 1; s_tdata = e.d; s_tlast = e.last;
    if (af_rand) almost_full = ($urandom_range(0, 3) == 0);
    n = 0;
    forever begin
      #1;
      if (s_tready) break;
      n++;
      if (n > 200) begin chk("ready_timeout", 0, 1); s_tvalid = 0; return; end
      @(negedge clk);
      if (af_rand) almost_full = ($urandom_range(0, 3) == 0);
    end
    @(posedge clk);
    if (push) expq.push_back(e);
  endtask

  task automatic send_frame(input int n, input int d);
    make_frame(n, d);
    foreach (fr[i]) send_beat(fr[i], 1);
  endtask

  task automatic send_garbage(input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = 16'($urandom);
      e.last = ($urandom_range(0, 3) == 0);
      if (e.d == SFD_V) e.last = 1;
      send_beat(e, 0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk); s_tvalid = 0;
    while (expq.size() != 0 && n < 500) begin @(negedge clk); n++; end
    repeat (2) @(negedge clk);
    chk("drain", expq.size(), 0);
  endtask

  // output monitor: compares each forwarded beat with the next expectation
  initial begin
    exp_t e;
    drop_current = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (pkt_tvalid) begin
          if (expq.size() == 0) begin
            chk("spurious_beat", 1, 0);
            drop_current = 0;
          end else begin
            e = expq.pop_front();
            chk("tdata", pkt_tdata, e.d);
            chk("tlast", pkt_tlast, e.last);
            chk("status", status, e.st);
            chk("frame_done", frame_done, e.done);
            chk("incomplete", incomplete_frame, e.inc);
            if (e.done) begin
              chk("frame_len", frame_len, e.len);
              chk("frame_err", frame_err, e.err);
              chk("frame_dropped", frame_dropped, e.drp);
            end
            drop_current = e.drop_here;
          end
        end else begin
          chk("idle_pulse", {frame_done, incomplete_frame}, 0);
          drop_current = 0;
        end
      end
    end
  end

  initial begin
    reset = 1; s_tvalid = 0; s_tdata = 0; s_tlast = 0; almost_full = 0;
    #3;
    chk("rst_tvalid", pkt_tvalid, 0);
    chk("rst_status", status, 0);
    chk("rst_done", {frame_done, frame_len, frame_err}, 0);
    chk("rst_ready", s_tready, 0);
    repeat (2) @(negedge clk);
    reset = 0;

    // directed: good, runt, truncated followed by good, drop on 3rd payload beat
    send_frame(31, 0);
    send_frame(13, 0);
    send_frame(3, 0);
    send_frame(31, 0);
    send_frame(31, 11);
    drain();

    // backpressure arriving mid-frame holds until tlast is accepted
    make_frame(31, 0);
    for (int i = 0; i < 5; i++) send_beat(fr[i], 1);
    @(negedge clk); s_tvalid = 0; almost_full = 1;
    #1 chk("bp_inframe", s_tready, 1);
    for (int i = 5; i < 31; i++) send_beat(fr[i], 1);
    @(negedge clk); s_tvalid = 0;
    #1 chk("bp_after_last", s_tready, 0);
    almost_full = 0;
    #1 chk("bp_release", s_tready, 1);
    drain();

    // giant
    send_frame(762, 0);
    drain();

    // randomized mix with gaps, garbage, back-to-back frames and backpressure
    gap_max = 2; af_rand = 1;
    for (int f = 0; f < 20; f++) begin
      int n, d, cat;
      send_garbage($urandom_range(0, 2));
      cat = $urandom_range(0, 3);
      d = 0;
      case (cat)
        0: n = $urandom_range(2, 8);
        1: n = $urandom_range(9, 30);
        2: n = $urandom_range(31, 50);
        default: begin n = $urandom_range(10, 40); d = $urandom_range(1, n - 1); end
      endcase
      send_frame(n, d);
    end
    af_rand = 0; almost_full = 0; gap_max = 0;
    drain();

    // reset during SRC, then garbage must stay silent until the next SFD
    make_frame(31, 0);
    for (int i = 0; i < 6; i++) send_beat(fr[i], 1);
    @(negedge clk); s_tvalid = 0;
    #2 reset = 1;
    #1;
    chk("midrst_tvalid", pkt_tvalid, 0);
    chk("midrst_status", status, 0);
    chk("midrst_ready", s_tready, 0);
    chk("midrst_done", {frame_done, incomplete_frame, frame_len}, 0);
    repeat (2) @(negedge clk);
    reset = 0;
    expq.delete();
    send_garbage(6);
    send_frame(31, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/input_frame_parser.md
Name: input_frame_parser

Overview:
- Parametrised successor to the ingress frame scanner; sits between the ingress AXIS port and the input filter / packet FIFO.
- Registers each accepted beat, classifies it into preamble (SFD), destination MAC, source MAC, type and payload fields, and broadcasts per-beat field status to the filter.
- Adds configurable data width and field lengths, per-frame beat counting, runt/giant/truncation detection, a frame-done summary, and frame-boundary backpressure.

Parameters:
- DATA_W, 16, ingress tdata width in bits.
- SFD, 16'hAAAB (DATA_W bits), start-of-frame delimiter beat value.
- DST_BEATS, 3, beats in the destination MAC field.
- SRC_BEATS, 3, beats in the source MAC field.
- TYPE_BEATS, 1, beats in the type field.
- MIN_PAYLOAD_BEATS, 23, fewest payload beats for a good frame.
- MAX_PAYLOAD_BEATS, 750, most payload beats for a good frame.
- LEN_W, 12, width of the beat counters and frame_len; must hold MAX_PAYLOAD_BEATS plus all header beats plus 1.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- s_tvalid  in  1  ingress AXIS valid.
- s_tdata  in  DATA_W  ingress AXIS data.
- s_tlast  in  1  ingress AXIS last.
- s_tready  out  1  ingress AXIS ready.
- drop_current  in  1  filter verdict: drop the frame in flight.
- almost_full  in  1  downstream buffer cannot take another full frame.
- pkt_tvalid  out  1  registered beat valid.
- pkt_tdata  out  DATA_W  registered beat data.
- pkt_tlast  out  1  registered beat last.
- status  out  5  field of the registered beat: {payload,type,src,dst,frame}.
- incomplete_frame  out  1  one-cycle pulse when tlast arrives before the type field completes.
- frame_done  out  1  one-cycle pulse with the registered tlast beat of any started frame.
- frame_len  out  LEN_W  beats in that frame, SFD included; valid with frame_done.
- frame_err  out  2  error code, valid with frame_done: 00 ok, 01 runt, 10 giant, 11 truncated.
- frame_dropped  out  1  drop_current was seen during that frame; valid with frame_done.

Behaviour:
- Reset (async assert, sync release): all outputs 0; state IDLE; counters 0.
- Latency is 1 cycle. The beat accepted on edge t (s_tvalid & s_tready) appears on pkt_* after t. status and frame_* are aligned with that same beat. pkt_tvalid=0 on cycles with no accepted beat.
- Ready rule:
  - in_frame is set when the SFD beat is accepted and cleared when a tlast beat is accepted.
  - When in_frame=1, s_tready=1 regardless of almost_full.
  - When in_frame=0, s_tready = ~almost_full. This is registered-independent, so almost_full takes effect in the same cycle.
- States: IDLE, DST, SRC, TYPE, PAYLOAD, MASK. field_cnt counts beats within the current field and is cleared on each field change.
  - IDLE: a beat equal to SFD (without tlast) gives status 00001 and moves to DST. Any other beat gives status 0, is discarded, and produces no frame_done.
  - DST: status 00011; moves to SRC after DST_BEATS beats.
  - SRC: status 00101; moves to TYPE after SRC_BEATS beats.
  - TYPE: status 01001; moves to PAYLOAD after TYPE_BEATS beats.
  - PAYLOAD: status 10001. pay_cnt increments per beat, saturating at all-ones.
  - MASK: status 0; beats are still accepted and forwarded; leaves on tlast.
- tlast handling:
  - tlast in DST, SRC or TYPE (before TYPE completes): incomplete_frame=1, frame_err=11, next state IDLE.
  - tlast in PAYLOAD: frame_err=01 if pay_cnt < MIN_PAYLOAD_BEATS, otherwise 00. Next state IDLE.
- Giant: the payload beat that takes pay_cnt past MAX_PAYLOAD_BEATS is forwarded with status 0 and the state moves to MASK. The frame's frame_done reports 10.
- drop_current, sampled every cycle:
  - In a non-IDLE state with the registered beat not tlast: next state MASK and the sticky dropped flag is set.
  - When the registered beat is tlast: no MASK, return to IDLE, frame_dropped=1.
  - In IDLE: ignored.
- Error priority: truncated > giant > runt. Drop does not alter frame_err.
- frame_len counts every beat from SFD to tlast and saturates at all-ones.
- Back-to-back frames: the SFD may be accepted the cycle after tlast, with no idle beat required.

Optional Feature:
- Macro INPUT_PARSER_STATS_EN.
- When defined, adds four outputs: stat_good, stat_runt, stat_giant, stat_dropped, each 16 bits. They are saturating counters, incremented on frame_done per frame_err / frame_dropped, reset to 0, and cleared by input stat_clr (1 bit, synchronous).
- When not defined, these ports and logic are absent and the remaining behaviour is identical.

Test Plan:
- Good frame (defaults): SFD, 3 DST, 3 SRC, 1 TYPE, 23 payload beats with the last carrying tlast, 31 beats total. Required: status sequence 01,03×3,05×3,09,11×23 (hex); frame_done with frame_len=31, frame_err=00.
- Runt: SFD+7 header beats+5 payload beats, tlast on the last. Required: frame_err=01, frame_len=13, no incomplete_frame.
- Truncated: SFD+2 DST beats, tlast on the second. Required: incomplete_frame pulses once; frame_err=11, frame_len=3; next frame parses normally.
- Drop mid-frame: drop_current for 1 cycle on the 3rd payload beat. Required: remaining beats have status 0, s_tready stays 1; frame_done with frame_dropped=1, frame_err=00 for a 23-beat payload.
- Backpressure: almost_full=1 asserted mid-frame. Required: s_tready held 1 until tlast is accepted, then 0 the next cycle; deasserting almost_full restores s_tready the same cycle.
- Reset mid-frame: reset asserted during SRC. Required: all outputs 0 immediately; after release, garbage beats until SFD give status 0 and no frame_done.
